// File: rtl/vproc_bus_bridge.sv
// ---------------------------------------------------------------------------
// vproc_bus_bridge
//
// Purpose:
//   Turns the VProc virtual processor's level-held command interface
//   (Addr/WE/RD/DataOut plus the Update toggle) into exactly one request on a
//   simple valid/ready slave bus. It returns single-cycle WRAck/RDAck pulses
//   and DataIn to VProc. Only one access is outstanding at a time.
//
// Optional feature (compile-time macro VPROC_BRIDGE_TIMEOUT_EN):
//   When defined, a 16-bit counter aborts a request that has not seen
//   BusReady within TIMEOUT cycles. An aborted read returns ERR_DATA, and
//   Interrupt pulses ERR_IRQ together with the ack. When undefined, REQ waits
//   indefinitely and Interrupt is tied to 0.
//
// Parameters:
//   TIMEOUT   cycles a request may wait for BusReady (1..65535)
//   ERR_DATA  DataIn value returned on an aborted read
//   ERR_IRQ   Interrupt value pulsed on abort (nonzero)
//
// Ports:
//   Clk, nReset                  clock, async active-low reset
//   Addr, DataOut, WE, RD        VProc command (level-held)
//   Update / UpdateResponse      VProc new-command toggle and its echo
//   DataIn, WRAck, RDAck         read data and completion pulses to VProc
//   Interrupt                    error interrupt to VProc
//   BusAddr, BusWData            slave address / write data
//   BusWE, BusRE                 slave write / read request
//   BusReady, BusRData           slave accept/complete and read data
//
// States:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a new command (WE|RD with Update toggle or Rearm)
//   ST_REQ   | bus request held stable until BusReady (or timeout)
//   ST_ACK   | ack/Interrupt pulse is visible; clear it, back to IDLE
// ---------------------------------------------------------------------------
module vproc_bus_bridge #(
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
    parameter logic [2:0]  ERR_IRQ  = 3'b001
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [31:0] Addr,
    input  logic [31:0] DataOut,
    input  logic        WE,
    input  logic        RD,
    input  logic        Update,
    output logic        UpdateResponse,
    output logic [31:0] DataIn,
    output logic        WRAck,
    output logic        RDAck,
    output logic [2:0]  Interrupt,
    output logic [31:0] BusAddr,
    output logic [31:0] BusWData,
    output logic        BusWE,
    output logic        BusRE,
    input  logic        BusReady,
    input  logic [31:0] BusRData
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        upd_last;
    logic        rearm, rearm_nxt;
    logic [31:0] bus_addr_nxt, bus_wdata_nxt, data_in_nxt;
    logic        bus_we_nxt, bus_re_nxt, wr_ack_nxt, rd_ack_nxt;
    logic        new_cmd;

    // VProc updates must complete in zero time, so the echo is combinational.
    assign UpdateResponse = Update;

    // Rearm lets a level-held WE/RD be re-issued after reset without a toggle.
    assign new_cmd = (WE | RD) & ((Update != upd_last) | rearm);

`ifdef VPROC_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt, to_cnt_nxt;
    logic [2:0]  irq_nxt;
`else
    // Timeout parameters have no effect in this build.
    logic unused_cfg;
    assign unused_cfg = ^{ERR_DATA, ERR_IRQ, TIMEOUT[15:0]};
    assign Interrupt  = 3'b000;
`endif

    always_comb begin
        state_nxt     = state;
        rearm_nxt     = rearm;
        bus_addr_nxt  = BusAddr;
        bus_wdata_nxt = BusWData;
        bus_we_nxt    = BusWE;
        bus_re_nxt    = BusRE;
        data_in_nxt   = DataIn;
        wr_ack_nxt    = 1'b0;
        rd_ack_nxt    = 1'b0;
`ifdef VPROC_BRIDGE_TIMEOUT_EN
        to_cnt_nxt    = to_cnt;
        irq_nxt       = 3'b000;
`endif
        case (state)
            ST_IDLE: begin
                if (new_cmd) begin
                    bus_addr_nxt  = Addr;
                    bus_wdata_nxt = DataOut;
                    // WE and RD together are performed as a write only.
                    bus_we_nxt    = WE;
                    bus_re_nxt    = RD & ~WE;
                    rearm_nxt     = 1'b0;
`ifdef VPROC_BRIDGE_TIMEOUT_EN
                    to_cnt_nxt    = 16'd0;
`endif
                    state_nxt     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (BusReady) begin
                    bus_we_nxt = 1'b0;
                    bus_re_nxt = 1'b0;
                    if (BusRE) begin
                        data_in_nxt = BusRData;
                    end
                    wr_ack_nxt = BusWE;
                    rd_ack_nxt = BusRE;
                    state_nxt  = ST_ACK;
                end
`ifdef VPROC_BRIDGE_TIMEOUT_EN
                else if (to_cnt == TIMEOUT_TC) begin
                    bus_we_nxt = 1'b0;
                    bus_re_nxt = 1'b0;
                    if (BusRE) begin
                        data_in_nxt = ERR_DATA;
                    end
                    wr_ack_nxt = BusWE;
                    rd_ack_nxt = BusRE;
                    irq_nxt    = ERR_IRQ;
                    state_nxt  = ST_ACK;
                end else begin
                    to_cnt_nxt = to_cnt + 16'd1;
                end
`endif
            end
            ST_ACK: begin
                // Ack and Interrupt fall back to 0 via the defaults above.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= ST_IDLE;
            upd_last <= 1'b0;
            rearm    <= 1'b1;
            BusAddr  <= 32'd0;
            BusWData <= 32'd0;
            BusWE    <= 1'b0;
            BusRE    <= 1'b0;
            DataIn   <= 32'd0;
            WRAck    <= 1'b0;
            RDAck    <= 1'b0;
        end else begin
            state    <= state_nxt;
            upd_last <= Update;
            rearm    <= rearm_nxt;
            BusAddr  <= bus_addr_nxt;
            BusWData <= bus_wdata_nxt;
            BusWE    <= bus_we_nxt;
            BusRE    <= bus_re_nxt;
            DataIn   <= data_in_nxt;
            WRAck    <= wr_ack_nxt;
            RDAck    <= rd_ack_nxt;
        end
    end

`ifdef VPROC_BRIDGE_TIMEOUT_EN
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            to_cnt    <= 16'd0;
            Interrupt <= 3'b000;
        end else begin
            to_cnt    <= to_cnt_nxt;
            Interrupt <= irq_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_vproc_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_vproc_bus_bridge
//
// Directed plus randomized bench for vproc_bus_bridge. Expected values come
// from a transaction-level model: each command is classified as write, read
// or nothing, the expected DataIn is tracked as "last read data", and the
// number of bus requests issued is counted and compared with what the model
// predicts. Timeout abort is exercised when VPROC_BRIDGE_TIMEOUT_EN is set.
// ---------------------------------------------------------------------------
module tb_vproc_bus_bridge;

    localparam int TB_TIMEOUT = 8;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [31:0] Addr, DataOut;
    logic        WE, RD, Update;
    logic        UpdateResponse;
    logic [31:0] DataIn;
    logic        WRAck, RDAck;
    logic [2:0]  Interrupt;
    logic [31:0] BusAddr, BusWData;
    logic        BusWE, BusRE;
    logic        BusReady;
    logic [31:0] BusRData;

    always #5 Clk = ~Clk;

    vproc_bus_bridge #(
        .TIMEOUT (TB_TIMEOUT),
        .ERR_DATA(32'hDEADBEEF),
        .ERR_IRQ (3'b001)
    ) dut (
        .Clk           (Clk),
        .nReset        (nReset),
        .Addr          (Addr),
        .DataOut       (DataOut),
        .WE            (WE),
        .RD            (RD),
        .Update        (Update),
        .UpdateResponse(UpdateResponse),
        .DataIn        (DataIn),
        .WRAck         (WRAck),
        .RDAck         (RDAck),
        .Interrupt     (Interrupt),
        .BusAddr       (BusAddr),
        .BusWData      (BusWData),
        .BusWE         (BusWE),
        .BusRE         (BusRE),
        .BusReady      (BusReady),
        .BusRData      (BusRData)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] mdl_datain = 32'd0;
    int          exp_wr = 0;
    int          exp_rd = 0;

    // Request-start monitor (rising edges of BusWE/BusRE, sampled mid-cycle)
    int   wr_starts = 0;
    int   rd_starts = 0;
    logic prev_we = 1'b0;
    logic prev_re = 1'b0;

    always @(negedge Clk) begin
        if (BusWE && !prev_we) wr_starts++;
        if (BusRE && !prev_re) rd_starts++;
        prev_we = BusWE;
        prev_re = BusRE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_cmd(input logic we, input logic rd, input logic [31:0] a,
                             input logic [31:0] d, input logic toggle);
        @(negedge Clk);
        WE      = we;
        RD      = rd;
        Addr    = a;
        DataOut = d;
        if (toggle) Update = ~Update;
        #1;
        check("upd_echo", {31'd0, UpdateResponse}, {31'd0, Update});
    endtask

    // Completes a request already visible on the bus: wait_c cycles with
    // BusReady low (garbage on BusRData), then one BusReady cycle.
    task automatic finish_cmd(input logic is_wr, input logic is_rd, input int wait_c,
                              input logic [31:0] rdata);
        for (int i = 0; i < wait_c; i++) begin
            @(negedge Clk);
            BusReady = 1'b0;
            BusRData = $urandom;
            tick();
            check("hold_we", {31'd0, BusWE}, {31'd0, is_wr});
            check("hold_re", {31'd0, BusRE}, {31'd0, is_rd});
            check("hold_noack", {30'd0, WRAck, RDAck}, 32'd0);
        end
        @(negedge Clk);
        BusReady = 1'b1;
        BusRData = rdata;
        tick();
        if (is_rd) mdl_datain = rdata;
        check("done_req", {30'd0, BusWE, BusRE}, 32'd0);
        check("wrack", {31'd0, WRAck}, {31'd0, is_wr});
        check("rdack", {31'd0, RDAck}, {31'd0, is_rd});
        check("datain", DataIn, mdl_datain);
        check("irq_ok", {29'd0, Interrupt}, 32'd0);
        @(negedge Clk);
        BusReady = 1'b0;
        BusRData = $urandom;
        tick();
        check("ack_width", {30'd0, WRAck, RDAck}, 32'd0);
    endtask

    task automatic run_cmd(input logic we, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input int wait_c, input logic [31:0] rdata);
        logic is_wr, is_rd;
        is_wr = we;
        is_rd = rd & ~we;
        drive_cmd(we, rd, a, d, 1'b1);
        tick();
        check("req_we", {31'd0, BusWE}, {31'd0, is_wr});
        check("req_re", {31'd0, BusRE}, {31'd0, is_rd});
        if (is_wr || is_rd) begin
            check("req_addr", BusAddr, a);
            check("req_wdata", BusWData, d);
            if (is_wr) exp_wr++;
            if (is_rd) exp_rd++;
            finish_cmd(is_wr, is_rd, wait_c, rdata);
        end else begin
            tick();
            check("idle_noreq", {28'd0, BusWE, BusRE, WRAck, RDAck}, 32'd0);
        end
    endtask

    initial begin
        int wr_base;
        nReset   = 1'b0;
        Addr     = 32'd0;
        DataOut  = 32'd0;
        WE       = 1'b0;
        RD       = 1'b0;
        Update   = 1'b0;
        BusReady = 1'b0;
        BusRData = 32'd0;

        // Reset state
        #12;
        check("rst_ctl", {27'd0, BusWE, BusRE, WRAck, RDAck, UpdateResponse}, 32'd0);
        check("rst_irq", {29'd0, Interrupt}, 32'd0);
        check("rst_addr", BusAddr, 32'd0);
        check("rst_wdata", BusWData, 32'd0);
        check("rst_datain", DataIn, 32'd0);
        @(negedge Clk);
        nReset = 1'b1;
        tick();
        tick();
        check("idle_after_rst", {30'd0, BusWE, BusRE}, 32'd0);

        // Zero-wait write, then a read with three wait cycles
        run_cmd(1'b1, 1'b0, 32'h100, 32'hA5A5A5A5, 0, 32'h0);
        run_cmd(1'b0, 1'b1, 32'h200, 32'h0, 3, 32'h12345678);
        check("read_data", DataIn, 32'h12345678);

        // Back-to-back writes with WE held, then WE held without a toggle
        wr_base = wr_starts;
        run_cmd(1'b1, 1'b0, 32'h300, 32'h11111111, 0, 32'h0);
        run_cmd(1'b1, 1'b0, 32'h304, 32'h22222222, 1, 32'h0);
        check("b2b_writes", wr_starts - wr_base, 32'd2);
        for (int i = 0; i < 5; i++) tick();
        check("no_retrigger", wr_starts - wr_base, 32'd2);
        check("no_retrig_we", {31'd0, BusWE}, 32'd0);

        // WE and RD together: write only, DataIn unchanged
        run_cmd(1'b1, 1'b1, 32'h400, 32'h33333333, 2, 32'hCAFEF00D);
        check("werd_datain", DataIn, 32'h12345678);

        // Reset asserted mid-REQ, RD kept high: request re-issued via Rearm
        drive_cmd(1'b0, 1'b1, 32'h500, 32'h0, 1'b1);
        tick();
        check("pre_rst_re", {31'd0, BusRE}, 32'd1);
        exp_rd++;
        tick();
        #2 nReset = 1'b0;
        #1;
        check("async_rst_out", {27'd0, BusWE, BusRE, WRAck, RDAck, Interrupt[0]}, 32'd0);
        check("async_rst_datain", DataIn, 32'd0);
        mdl_datain = 32'd0;
        @(negedge Clk);
        @(negedge Clk);
        nReset = 1'b1;
        tick();
        check("rearm_re", {31'd0, BusRE}, 32'd1);
        check("rearm_addr", BusAddr, 32'h500);
        exp_rd++;
        finish_cmd(1'b0, 1'b1, 0, 32'h0BADC0DE);

        // Expiry-cycle BusReady wins over the timeout
        run_cmd(1'b0, 1'b1, 32'h600, 32'h0, TB_TIMEOUT - 1, 32'h55AA55AA);

`ifdef VPROC_BRIDGE_TIMEOUT_EN
        // Read with BusReady never high: aborted after TIMEOUT cycles
        drive_cmd(1'b0, 1'b1, 32'h700, 32'h0, 1'b1);
        exp_rd++;
        tick();
        for (int i = 1; i < TB_TIMEOUT; i++) begin
            tick();
            check("to_hold_re", {31'd0, BusRE}, 32'd1);
            check("to_noack", {28'd0, RDAck, Interrupt}, 32'd0);
        end
        tick();
        mdl_datain = 32'hDEADBEEF;
        check("to_drop_re", {31'd0, BusRE}, 32'd0);
        check("to_rdack", {31'd0, RDAck}, 32'd1);
        check("to_irq", {29'd0, Interrupt}, 32'd1);
        check("to_datain", DataIn, 32'hDEADBEEF);
        tick();
        check("to_pulse_end", {28'd0, RDAck, Interrupt}, 32'd0);
`endif

        // Randomized commands, including no-op (WE=RD=0) updates
        for (int n = 0; n < 24; n++) begin
            run_cmd(1'($urandom), 1'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 4)), $urandom);
        end

        tick();
        check("total_writes", wr_starts, exp_wr);
        check("total_reads", rd_starts, exp_rd);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
